boot_word_packer: RTL and testbench

- Upstream stage of the boot RAM loader.
- Takes the byte stream from the UART receiver and parses an 8-byte little-endian header: load address, then payload size in bytes.
- Packs payload bytes into little-endian 32-bit words and buffers them in a small FIFO.
- Exposes the FIFO through a read-request/acknowledge port to the RAM-writing stage, plus header values and completion status.

---
 rtl/boot_loader_pkg.sv | 18 +
 rtl/boot_word_packer_if.sv | 22 ++
 rtl/boot_word_fifo.sv | 64 ++++++
 rtl/boot_word_packer.sv | 169 ++++++++++++++++
 tb/tb_boot_word_packer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot RAM loader front end.
package boot_loader_pkg;

  localparam int unsigned HDR_BYTES  = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_WORDS  = HDR_BYTES / WORD_BYTES;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

  typedef logic [8*WORD_BYTES-1:0] word_t;

  typedef enum logic [1:0] {
    HDR_ADDR,
    HDR_SIZE,
    PAYLOAD,
    DONE
  } state_e;

endpackage

// File: rtl/boot_word_packer_if.sv
// Byte-in / word-out handshake bundle between UART receiver, packer and RAM writer.
interface boot_word_packer_if;
  import boot_loader_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       read_enable;
  logic       rx_ack;
  word_t      data;
  logic       empty;

  modport master (
    output rx_byte, rx_valid, read_enable,
    input  rx_ack, data, empty
  );

  modport slave (
    input  rx_byte, rx_valid, read_enable,
    output rx_ack, data, empty
  );

endinterface

// File: rtl/boot_word_fifo.sv
// Synchronous word FIFO with registered occupancy count and synchronous clear.
module boot_word_fifo
  import boot_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic  clk_sys_i,
  input  logic  rst_sys_ni,
  input  logic  clear,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output word_t head_data,
  output logic  empty,
  output logic  full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  word_t            mem [FIFO_DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/boot_word_packer.sv
// Parses the 8-byte boot header, packs payload bytes into LE words and
// serves them to the RAM writer through a request/acknowledge read port.
module boot_word_packer
  import boot_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic                clear_i,
  boot_word_packer_if.slave   bus,
  output word_t               addr_ini_o,
  output word_t               size_o,
  output logic                hdr_valid_o,
  output logic                done_o,
  output logic                overflow_o
);

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  word_t             asm_q, asm_d;
  word_t             rem_q, rem_d;
  word_t             addr_q, addr_d;
  word_t             size_q, size_d;
  logic              hdr_valid_q, hdr_valid_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  word_t             data_q;
  logic              ack_q;

  word_t             byte_word;
  logic              lane_last;
  logic              take_byte;
  logic              push;
  logic              pop;
  word_t             head_word;
  logic              fifo_empty;
  logic              fifo_full;

  // Assembly register is zeroed after every completed word, so a short
  // final word comes out with its unreceived upper lanes already zero.
  assign byte_word = asm_q | (word_t'(bus.rx_byte) << {lane_q, 3'b000});
  assign lane_last = (lane_q == LANE_W'(WORD_BYTES - 1));
  assign take_byte = bus.rx_valid && (state_q != DONE);
  assign pop       = bus.read_enable && !fifo_empty && !ack_q && !clear_i;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) state_q <= HDR_ADDR;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    size_d      = size_q;
    hdr_valid_d = hdr_valid_q;
    done_d      = done_q;
    push        = 1'b0;

    if (take_byte) begin
      lane_d = lane_q + LANE_W'(1);
      asm_d  = byte_word;
      case (state_q)
        HDR_ADDR: begin
          if (lane_last) begin
            addr_d  = byte_word;
            asm_d   = '0;
            state_d = HDR_SIZE;
          end
        end
        HDR_SIZE: begin
          if (lane_last) begin
            size_d      = byte_word;
            rem_d       = byte_word;
            hdr_valid_d = 1'b1;
            asm_d       = '0;
            if (byte_word == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          rem_d = rem_q - word_t'(1);
          if (lane_last || rem_q == word_t'(1)) begin
            push   = 1'b1;
            asm_d  = '0;
            lane_d = '0;
          end
          if (rem_q == word_t'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    overflow_d = overflow_q | (push && fifo_full && !pop);

    if (clear_i) begin
      state_d     = HDR_ADDR;
      lane_d      = '0;
      asm_d       = '0;
      rem_d       = '0;
      addr_d      = '0;
      size_d      = '0;
      hdr_valid_d = 1'b0;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
      push        = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      lane_q      <= '0;
      asm_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      hdr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      data_q      <= '0;
      ack_q       <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      hdr_valid_q <= hdr_valid_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      ack_q       <= pop;
      if (pop) data_q <= head_word;
    end
  end

  boot_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .clear      (clear_i),
    .push       (push),
    .push_data  (byte_word),
    .pop        (pop),
    .head_data  (head_word),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign bus.rx_ack  = ack_q;
  assign bus.data    = data_q;
  assign bus.empty   = fifo_empty;
  assign addr_ini_o  = addr_q;
  assign size_o      = size_q;
  assign hdr_valid_o = hdr_valid_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_boot_word_packer.sv
// Directed bench for boot_word_packer: byte-stream vector table plus
// hand-written sequences for overflow, streaming reads, clear and reset.
module tb_boot_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] addr_ini, size;
  logic        hdr_valid, done, overflow;

  boot_word_packer_if bus ();

  boot_word_packer #(.FIFO_DEPTH(8)) dut (
    .clk_sys_i   (clk),
    .rst_sys_ni  (rst_n),
    .clear_i     (clear),
    .bus         (bus),
    .addr_ini_o  (addr_ini),
    .size_o      (size),
    .hdr_valid_o (hdr_valid),
    .done_o      (done),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [7:0]  b;
    logic [31:0] addr;
    logic [31:0] size;
    logic        hv;
    logic        dn;
    logic        em;
  } vec_t;

  vec_t vec[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void add_seg(input logic [7:0] bs[$], input logic [31:0] a,
                                  input logic [31:0] s, input int dn_at, input int em_from);
    for (int k = 1; k <= bs.size(); k++) begin
      vec.push_back('{(k == 1), bs[k-1], (k >= 4) ? a : 32'h0, (k >= 8) ? s : 32'h0,
                      (k >= 8), (k >= dn_at), !(k >= em_from)});
    end
  endfunction

  // Streaming scoreboard: independent occupancy/ack model driven by the bench's own push marks.
  logic        word_end = 1'b0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          m_cnt = 0;
  bit          m_ack = 1'b0;
  bit          m_push, m_pop;
  int          last_ack = -1;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (mon_en) begin
      m_push = bus.rx_valid && word_end;
      m_pop  = bus.read_enable && (m_cnt != 0) && !m_ack && !clear;
      m_cnt  = m_cnt + int'(m_push) - int'(m_pop);
      m_ack  = m_pop;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("stream.empty", bus.empty, (m_cnt == 0));
      check("stream.ack", bus.rx_ack, m_ack);
      if (bus.rx_ack) begin
        if (last_ack >= 0) check("stream.ack_gap", ((cyc - last_ack) >= 2), 1);
        last_ack = cyc;
        if (exp_q.size() == 0) check("stream.unexpected_ack", bus.rx_ack, 0);
        else check("stream.data", bus.data, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic wend = 1'b0);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    word_end     = wend;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    word_end     = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] a, input logic [31:0] s);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(s[8*i +: 8]);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pop_word(input string name, input logic [31:0] exp);
    bit got = 1'b0;
    bus.read_enable = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.rx_ack) got = 1'b1;
    end
    bus.read_enable = 1'b0;
    if (!got) check({name, ".timeout"}, 0, 1);
    else      check(name, bus.data, exp);
  endtask

  task automatic count_acks(input int cycles, output int n);
    n = 0;
    bus.read_enable = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.rx_ack) n++;
    end
    bus.read_enable = 1'b0;
  endtask

  function automatic logic [31:0] seq_word(input int base);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(base);
    b1 = 8'(base + 1);
    b2 = 8'(base + 2);
    b3 = 8'(base + 3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vec[i].clr) pulse_clear();
      send_byte(vec[i].b);
      check($sformatf("v%0d.addr", i), addr_ini, vec[i].addr);
      check($sformatf("v%0d.size", i), size, vec[i].size);
      check($sformatf("v%0d.hdr_valid", i), hdr_valid, vec[i].hv);
      check($sformatf("v%0d.done", i), done, vec[i].dn);
      check($sformatf("v%0d.empty", i), bus.empty, vec[i].em);
    end
  endtask

  task automatic clear_status_checks(input string tag, input logic [31:0] exp_data);
    check({tag, ".empty"}, bus.empty, 1);
    check({tag, ".hdr_valid"}, hdr_valid, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".overflow"}, overflow, 0);
    check({tag, ".addr"}, addr_ini, 0);
    check({tag, ".size"}, size, 0);
    check({tag, ".ack"}, bus.rx_ack, 0);
    check({tag, ".data"}, bus.data, exp_data);
  endtask

  task automatic reparse(input string tag);
    send_header(32'h1234_5678, 32'd4);
    check({tag, ".new_addr"}, addr_ini, 32'h1234_5678);
    check({tag, ".new_size"}, size, 32'd4);
    check({tag, ".new_hv"}, hdr_valid, 1);
    for (int p = 0; p < 4; p++) send_byte(8'hA1 + 8'(p));
    check({tag, ".new_done"}, done, 1);
    pop_word({tag, ".new_word"}, 32'hA4A3_A2A1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] bs[$];
    int n;

    bs = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_seg(bs, 32'h0010_0000, 32'd8, 16, 12);
    bs = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h06, 8'h00, 8'h00, 8'h00,
           8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    add_seg(bs, 32'h2000_0000, 32'd6, 14, 12);
    bs = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    add_seg(bs, 32'h0000_0100, 32'd0, 8, 100);

    bus.rx_byte     = '0;
    bus.rx_valid    = 1'b0;
    bus.read_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.ack", bus.rx_ack, 0);
    check("reset.data", bus.data, 0);
    check("reset.empty", bus.empty, 1);
    check("reset.addr", addr_ini, 0);
    check("reset.size", size, 0);
    check("reset.hdr_valid", hdr_valid, 0);
    check("reset.done", done, 0);
    check("reset.overflow", overflow, 0);

    // size 8, full words
    run_vec(0, 15);
    pop_word("a.word0", 32'h4433_2211);
    pop_word("a.word1", 32'h8877_6655);
    check("a.done", done, 1);
    check("a.empty", bus.empty, 1);

    // size 6, zero-filled partial word
    run_vec(16, 29);
    pop_word("b.word0", 32'hDDCC_BBAA);
    pop_word("b.word1", 32'h0000_FFEE);
    check("b.empty", bus.empty, 1);

    // size 0
    run_vec(30, 37);
    count_acks(10, n);
    check("c.no_ack", n, 0);
    check("c.empty", bus.empty, 1);
    send_byte(8'h5A);
    check("c.done_ignores_rx", size, 0);

    // size 40, no reads: words 9 and 10 dropped
    pulse_clear();
    send_header(32'h0, 32'd40);
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(i));
      if (i == 31) check("ovf.before_full", overflow, 0);
      if (i == 35) check("ovf.word9_dropped", overflow, 1);
    end
    check("ovf.done", done, 1);
    check("ovf.sticky", overflow, 1);
    for (int w = 0; w < 8; w++) pop_word($sformatf("ovf.word%0d", w), seq_word(4 * w));
    check("ovf.drained_empty", bus.empty, 1);
    count_acks(6, n);
    check("ovf.no_extra_word", n, 0);

    // size 36: ninth word pushed while full but popped in the same cycle
    pulse_clear();
    send_header(32'h0, 32'd36);
    for (int i = 0; i < 35; i++) send_byte(8'(i));
    check("full.empty", bus.empty, 0);
    bus.rx_byte     = 8'd35;
    bus.rx_valid    = 1'b1;
    bus.read_enable = 1'b1;
    @(negedge clk);
    bus.rx_valid    = 1'b0;
    bus.read_enable = 1'b0;
    check("full.ack", bus.rx_ack, 1);
    check("full.word0", bus.data, 32'h0302_0100);
    check("full.no_overflow", overflow, 0);
    check("full.done", done, 1);
    for (int w = 1; w <= 8; w++) pop_word($sformatf("full.word%0d", w), seq_word(4 * w));
    check("full.empty_end", bus.empty, 1);

    // streaming with read_enable held, scoreboarded every cycle
    pulse_clear();
    m_cnt = 0;
    m_ack = 1'b0;
    last_ack = -1;
    for (int w = 0; w < 5; w++) exp_q.push_back(seq_word(8'h40 + 4 * w));
    mon_en = 1'b1;
    send_header(32'h0, 32'd20);
    for (int p = 0; p < 12; p++) send_byte(8'h40 + 8'(p), ((p % 4) == 3));
    bus.read_enable = 1'b1;
    @(negedge clk);
    for (int p = 12; p < 20; p++) begin
      bus.rx_byte  = 8'h40 + 8'(p);
      bus.rx_valid = 1'b1;
      word_end     = ((p % 4) == 3) || (p == 19);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    word_end     = 1'b0;
    repeat (12) @(negedge clk);
    bus.read_enable = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("stream.all_words_seen", exp_q.size(), 0);
    check("stream.done", done, 1);

    // clear mid-payload coinciding with a byte and a read request
    pulse_clear();
    send_header(32'hCAFE_0000, 32'd8);
    for (int p = 1; p <= 5; p++) send_byte(8'(p));
    pop_word("clr.pre_word", 32'h0403_0201);
    bus.rx_byte     = 8'h99;
    bus.rx_valid    = 1'b1;
    bus.read_enable = 1'b1;
    clear           = 1'b1;
    @(negedge clk);
    bus.rx_valid    = 1'b0;
    bus.read_enable = 1'b0;
    clear           = 1'b0;
    clear_status_checks("clr", 32'h0403_0201);
    reparse("clr");

    // asynchronous reset mid-payload
    pulse_clear();
    send_header(32'hCAFE_0000, 32'd8);
    for (int p = 1; p <= 5; p++) send_byte(8'(p));
    pop_word("rst.pre_word", 32'h0403_0201);
    #1 rst_n = 1'b0;
    #1 clear_status_checks("rst", 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    clear_status_checks("rst_after", 32'h0);
    reparse("rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
